// File: rtl/cpu_cc_pkg.sv
// ============================================================================
//  cpu_cc_pkg : CC bit positions, condition function codes and CC value type
//  Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package cpu_cc_pkg;

   typedef logic [3:0] cc_t;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [3:0] C_ALWAYS = 4'd0;
   localparam logic [3:0] C_LE     = 4'd1;
   localparam logic [3:0] C_L      = 4'd2;
   localparam logic [3:0] C_E      = 4'd3;
   localparam logic [3:0] C_NE     = 4'd4;
   localparam logic [3:0] C_GE     = 4'd5;
   localparam logic [3:0] C_G      = 4'd6;

endpackage

`default_nettype wire

// File: rtl/cond_table.sv
// ============================================================================
//  cond_table : combinational map (ifun, flags) -> (cnd, err)
//  Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module cond_table
   import cpu_cc_pkg::*;
(
   input  logic [3:0] ifun,
   input  cc_t        flags,
   output logic       cnd,
   output logic       err
);

   logic w_zf;
   logic w_sf;
   logic w_of;
   logic w_lt;
   logic w_unused_rsvd;

   assign w_zf          = flags[CC_ZF];
   assign w_sf          = flags[CC_SF];
   assign w_of          = flags[CC_OF];
   assign w_lt          = w_sf ^ w_of;
   // Bit 3 of the CC register is reserved and never affects a condition.
   assign w_unused_rsvd = flags[3];

   always_comb begin
      cnd = 1'b0;
      err = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = w_lt | w_zf;
         C_L:      cnd = w_lt;
         C_E:      cnd = w_zf;
         C_NE:     cnd = ~w_zf;
         C_GE:     cnd = ~w_lt;
         C_G:      cnd = ~w_lt & ~w_zf;
         default:  err = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/cond_eval.sv
// ============================================================================
//  cond_eval : resolves jXX/cmovXX conditions against the (forwarded) CC value
//              and returns a registered result over a valid/ready handshake.
//              Optional statistics counters behind macro COND_STATS_EN.
//  Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module cond_eval
   import cpu_cc_pkg::*;
#(
   parameter int TAG_W = 4
`ifdef COND_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  cc_t              cc,
   input  cc_t              new_cc,
   input  logic             set_cc,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_ifun,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_cnd,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag
`ifdef COND_STATS_EN
   ,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_cnd;
   logic             r_err;
   logic [TAG_W-1:0] r_tag;
   cc_t              w_eff;
   logic             w_cnd;
   logic             w_err;
   logic             w_accept;

   // A CC write in the accept cycle is visible to the request issued with it.
   assign w_eff    = set_cc ? new_cc : cc;
   assign w_accept = req_valid && req_ready;

   cond_table u_table (
      .ifun  (req_ifun),
      .flags (w_eff),
      .cnd   (w_cnd),
      .err   (w_err)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_next_state = S_FULL;
         S_FULL:  if (w_accept) w_next_state = S_FULL;
                  else if (rsp_ready) w_next_state = S_EMPTY;
         default: w_next_state = S_EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= S_EMPTY;
         r_cnd   <= 1'b0;
         r_err   <= 1'b0;
         r_tag   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_cnd <= w_cnd;
            r_err <= w_err;
            r_tag <= req_tag;
         end
      end
   end

   assign rsp_valid = (r_state == S_FULL);
   assign req_ready = !rsp_valid || rsp_ready;
   assign rsp_cnd   = r_cnd;
   assign rsp_err   = r_err;
   assign rsp_tag   = r_tag;

`ifdef COND_STATS_EN
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_taken_cnt <= '0;
         r_err_cnt   <= '0;
      end else if (w_accept) begin
         if (w_cnd && !w_err && (r_taken_cnt != '1))
            r_taken_cnt <= r_taken_cnt + 1'b1;
         if (w_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign taken_cnt = r_taken_cnt;
   assign err_cnt   = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/cond_eval.md
Name: cond_eval

Overview:
- Consumer side of the condition-code register: reads the 4-bit CC value and resolves jXX/cmovXX conditions for the sequential CPU's execute stage.
- Accepts a condition request (ifun + tag) over a valid/ready handshake and returns a registered cnd result one cycle later.
- Forwards a same-cycle CC write (set_cc/new_cc), so a request issued alongside an OPq sees the updated flags.

Parameters:
- TAG_W, 4, width of the opaque request tag carried through to the response.
- CNT_W, 16, width of the statistics counters (used only with COND_STATS_EN).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; reset==0 at a posedge resets the block.
- cc  input  4  current CC register value; bit2=ZF, bit1=SF, bit0=OF, bit3 reserved/ignored.
- new_cc  input  4  CC value being written this cycle.
- set_cc  input  1  CC write strobe this cycle.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_ifun  input  4  condition function code.
- req_tag  input  TAG_W  tag echoed on the response.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response when rsp_valid && rsp_ready.
- rsp_cnd  output  1  condition result.
- rsp_err  output  1  ifun was not a defined condition.
- rsp_tag  output  TAG_W  echoed tag.

Behaviour:
- Reset (reset==0 at posedge): rsp_valid=0, rsp_cnd=0, rsp_err=0, rsp_tag=0, counters=0. Any in-flight response is dropped; reset takes precedence over all other inputs.
- Effective flags: eff = set_cc ? new_cc : cc, sampled in the accept cycle. A response already in the register is never re-evaluated.
- Condition table (ZF=eff[2], SF=eff[1], OF=eff[0]):
  - 0 always=1
  - 1 le=(SF^OF)|ZF
  - 2 l=SF^OF
  - 3 e=ZF
  - 4 ne=~ZF
  - 5 ge=~(SF^OF)
  - 6 g=~(SF^OF)&~ZF
  - 7-15: cnd=0, err=1
- Defined codes give err=0.
- Two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1), on a single output register.
- req_ready = !rsp_valid || rsp_ready. This is combinational from rsp_ready and is the only combinational path.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + drain, no accept -> EMPTY.
  - FULL + drain + accept (same cycle) -> FULL with the new result; back-to-back throughput is 1 per cycle.
  - FULL, no drain -> hold all rsp_* stable.
- Latency: accept at edge N, response visible after edge N.
- req_* are don't-care when req_valid=0. No state changes without a handshake.

Optional Feature:
- Macro: COND_STATS_EN.
- When defined, adds two outputs:
  - taken_cnt [CNT_W-1:0]: increments on each accepted request with cnd=1 and err=0.
  - err_cnt [CNT_W-1:0]: increments on each accepted request with err=1.
- Both counters saturate at all-ones, reset to 0, and do not count ifun=0 (always) separately.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_cc_pkg holds:
  - CC bit index constants (CC_ZF=2, CC_SF=1, CC_OF=0).
  - ifun code constants (C_ALWAYS..C_G).
  - The 4-bit cc typedef.
- The CC register and this block both use the package.
- One sub-module, cond_table: a purely combinational map (ifun, flags) -> (cnd, err). It is reused by the top-level and by the bench reference model.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_valid=1 -> rsp_valid=0, rsp_cnd=0, rsp_tag=0; after reset=1, req_ready=1.
- Table sweep: cc=4'b0100 (ZF), ifun 0..6, rsp_ready=1 -> cnd=1,1,0,1,0,1,0. Then cc=4'b0010 (SF only) -> cnd=1,1,1,0,1,0,0.
- Invalid code: ifun=9, tag=4'hA -> rsp_cnd=0, rsp_err=1, rsp_tag=4'hA.
- Forwarding: cc=4'b0000, set_cc=1, new_cc=4'b0100, ifun=3 in the same cycle -> cnd=1. Repeat with set_cc=0 -> cnd=0.
- Backpressure: rsp_ready=0 with a response held -> req_ready=0, rsp_* stable for 5 cycles despite cc changes. Then rsp_ready=1 with a new request in the same cycle -> next response loaded with no bubble.
- COND_STATS_EN: 3 taken, 2 not-taken, 1 invalid accepted -> taken_cnt=3, err_cnt=1. With CNT_W=2 and 5 taken -> taken_cnt saturates at 3.
